// File: rtl/vw_chunk_sequencer_if.sv
// rtl/vw_chunk_sequencer_if.sv - upstream, matmul and downstream signals of the chunk sequencer
interface vw_chunk_sequencer_if #(
  parameter int NBits       = 8,
  parameter int WorkingRegs = 4
);
  // upstream element stream
  logic                         in_valid;
  logic                         in_ready;
  logic [NBits-1:0]             in_elem;
  // matmul side
  logic                         mm_in_data_ready;
  logic [WorkingRegs*NBits-1:0] mm_in_data;
  logic                         mm_req_chunk_in;
  logic                         mm_req_chunk_ptr_rst;
  logic                         mm_req_chunk_out;
  logic [NBits-1:0]             mm_write_out_data;
  logic                         mm_out_vector_valid;
  // downstream element stream
  logic                         out_valid;
  logic                         out_ready;
  logic [NBits-1:0]             out_elem;
  logic                         out_last;

  // sequencer side
  modport master (
    input  in_valid, in_elem,
    output in_ready,
    output mm_in_data_ready, mm_in_data,
    input  mm_req_chunk_in, mm_req_chunk_ptr_rst, mm_req_chunk_out,
    input  mm_write_out_data, mm_out_vector_valid,
    output out_valid, out_elem, out_last,
    input  out_ready
  );

  // upstream source, matmul and downstream sink side
  modport slave (
    output in_valid, in_elem,
    input  in_ready,
    input  mm_in_data_ready, mm_in_data,
    output mm_req_chunk_in, mm_req_chunk_ptr_rst, mm_req_chunk_out,
    output mm_write_out_data, mm_out_vector_valid,
    input  out_valid, out_elem, out_last,
    output out_ready
  );
endinterface

// File: rtl/vw_chunk_sequencer.sv
// rtl/vw_chunk_sequencer.sv - collects an input vector, serves it in chunks to a matmul, replays its output
module vw_chunk_sequencer #(
  parameter int InVecLength   = 16,
  parameter int OutVecLength  = 8,
  parameter int WorkingRegs   = 4,
  parameter int NBits         = 8,
  parameter int TimeoutCycles = 4096
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  vw_chunk_sequencer_if.master   bus,
  output logic                   busy,
  output logic                   err
);

  localparam int NChunks = InVecLength / WorkingRegs;
  localparam int FW = (InVecLength > 1) ? $clog2(InVecLength) : 1;
  localparam int CW = (NChunks > 1) ? $clog2(NChunks) : 1;
  localparam int OW = $clog2(OutVecLength + 1);
  localparam int RW = (OutVecLength > 1) ? $clog2(OutVecLength) : 1;
  localparam int TW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

  localparam logic [FW-1:0] FillLast  = FW'(InVecLength - 1);
  localparam logic [CW-1:0] ChunkLast = CW'(NChunks - 1);
  localparam logic [OW-1:0] OutFull   = OW'(OutVecLength);
  localparam logic [RW-1:0] RdLast    = RW'(OutVecLength - 1);
  localparam logic [TW-1:0] RunLast   = TW'(TimeoutCycles - 1);

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]                          r_state;
  logic [InVecLength-1:0][NBits-1:0]   r_buf;
  logic [OutVecLength-1:0][NBits-1:0]  r_obuf;
  logic [FW-1:0]                       r_fill_cnt;
  logic [CW-1:0]                       r_chunk_ptr;
  logic [OW-1:0]                       r_out_wr_ptr;
  logic [RW-1:0]                       r_out_rd_ptr;
  logic [TW-1:0]                       r_run_cnt;
  logic                                r_err;

  logic [FW-1:0] w_chunk_base;
  logic [RW-1:0] w_wr_idx;
  logic          w_wr_full;
  logic          w_wr_take;
  logic [OW-1:0] w_post_cnt;

  assign w_chunk_base = FW'(int'(r_chunk_ptr) * WorkingRegs);
  assign w_wr_idx     = r_out_wr_ptr[RW-1:0];
  assign w_wr_full    = (r_out_wr_ptr == OutFull);
  assign w_wr_take    = bus.mm_req_chunk_out & ~w_wr_full;
  // number of output entries written once this cycle's strobe lands
  assign w_post_cnt   = r_out_wr_ptr + OW'(w_wr_take);

  assign bus.in_ready         = (r_state == S_FILL);
  assign bus.mm_in_data_ready = (r_state == S_START);
  assign bus.mm_in_data       = r_buf[w_chunk_base +: WorkingRegs];
  assign bus.out_valid        = (r_state == S_DRAIN);
  assign bus.out_elem         = r_obuf[r_out_rd_ptr];
  assign bus.out_last         = (r_state == S_DRAIN) && (r_out_rd_ptr == RdLast);
  assign busy                 = (r_state != S_FILL);
  assign err                  = r_err;

  // state machine with input buffer fill, chunk pointer, output capture, watchdog and drain
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_FILL;
      r_buf        <= '0;
      r_obuf       <= '0;
      r_fill_cnt   <= '0;
      r_chunk_ptr  <= '0;
      r_out_wr_ptr <= '0;
      r_out_rd_ptr <= '0;
      r_run_cnt    <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_FILL: begin
          if (bus.in_valid) begin
            r_buf[r_fill_cnt] <= bus.in_elem;
            if (r_fill_cnt == FillLast) begin
              r_fill_cnt   <= '0;
              r_chunk_ptr  <= '0;
              r_out_wr_ptr <= '0;
              r_state      <= S_START;
            end else begin
              r_fill_cnt <= r_fill_cnt + FW'(1);
            end
          end
        end
        S_START: begin
          // output entries the matmul never writes must read back as 0
          r_obuf    <= '0;
          r_run_cnt <= '0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          // rewind wins over advance
          if (bus.mm_req_chunk_ptr_rst) begin
            r_chunk_ptr <= '0;
          end else if (bus.mm_req_chunk_in) begin
            r_chunk_ptr <= (r_chunk_ptr == ChunkLast) ? '0 : r_chunk_ptr + CW'(1);
          end
          if (w_wr_take) begin
            r_obuf[w_wr_idx] <= bus.mm_write_out_data;
            r_out_wr_ptr     <= r_out_wr_ptr + OW'(1);
          end else if (bus.mm_req_chunk_out) begin
            r_err <= 1'b1;
          end
          if (bus.mm_out_vector_valid) begin
            if (w_post_cnt != OutFull) begin
              r_err <= 1'b1;
            end
            r_out_rd_ptr <= '0;
            r_state      <= S_DRAIN;
          end else if (r_run_cnt == RunLast) begin
            r_err      <= 1'b1;
            r_buf      <= '0;
            r_fill_cnt <= '0;
            r_state    <= S_FILL;
          end else begin
            r_run_cnt <= r_run_cnt + TW'(1);
          end
        end
        default: begin
          if (bus.out_ready) begin
            if (r_out_rd_ptr == RdLast) begin
              r_state <= S_FILL;
            end else begin
              r_out_rd_ptr <= r_out_rd_ptr + RW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vw_chunk_sequencer.sv
// tb/tb_vw_chunk_sequencer.sv - directed self-checking bench for vw_chunk_sequencer
module tb_vw_chunk_sequencer;

  logic clk_in;
  logic rst_in;
  logic busy;
  logic err;
  int   errors;
  int   checks;

  vw_chunk_sequencer_if #(.NBits(8), .WorkingRegs(4)) bus_if ();

  vw_chunk_sequencer #(
    .InVecLength(16), .OutVecLength(8), .WorkingRegs(4), .NBits(8), .TimeoutCycles(32)
  ) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus_if.master),
    .busy   (busy),
    .err    (err)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.in_valid             = 1'b0;
    bus_if.in_elem              = '0;
    bus_if.mm_req_chunk_in      = 1'b0;
    bus_if.mm_req_chunk_ptr_rst = 1'b0;
    bus_if.mm_req_chunk_out     = 1'b0;
    bus_if.mm_write_out_data    = '0;
    bus_if.mm_out_vector_valid  = 1'b0;
    bus_if.out_ready            = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;
    step();
  endtask

  task automatic fill_vec(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.in_elem  = 8'(first + i);
      step();
    end
    bus_if.in_valid = 1'b0;
  endtask

  task automatic pulse_out(input logic [7:0] d, input logic last);
    bus_if.mm_req_chunk_out    = 1'b1;
    bus_if.mm_write_out_data   = d;
    bus_if.mm_out_vector_valid = last;
    step();
    bus_if.mm_req_chunk_out    = 1'b0;
    bus_if.mm_out_vector_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_in = 1'b0;
    #2;
    checks++;
    if ({bus_if.in_ready, bus_if.mm_in_data_ready, bus_if.out_valid, bus_if.out_last, busy, err} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_flags got %b expected 100000",
               {bus_if.in_ready, bus_if.mm_in_data_ready, bus_if.out_valid, bus_if.out_last, busy, err});
    end
    checks++;
    if (bus_if.mm_in_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mm_in_data got %h expected 00000000", bus_if.mm_in_data);
    end
    step();
    rst_in = 1'b1;
    step();
    // matmul strobes while filling must be ignored
    bus_if.mm_req_chunk_out    = 1'b1;
    bus_if.mm_out_vector_valid = 1'b1;
    bus_if.mm_req_chunk_in     = 1'b1;
    step();
    step();
    idle_inputs();
    checks++;
    if ({busy, err, bus_if.in_ready, bus_if.out_valid} !== 4'b0010) begin
      errors++;
      $display("FAIL strobes_in_fill got %b expected 0010", {busy, err, bus_if.in_ready, bus_if.out_valid});
    end
  endtask

  task automatic test_fill_and_chunks();
    do_reset();
    fill_vec(1, 15);
    checks++;
    if ({bus_if.mm_in_data_ready, bus_if.in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL before_last_accept got %b expected 010", {bus_if.mm_in_data_ready, bus_if.in_ready, busy});
    end
    fill_vec(16, 1);
    checks++;
    if ({bus_if.mm_in_data_ready, bus_if.in_ready, busy} !== 3'b101) begin
      errors++;
      $display("FAIL start_cycle got %b expected 101", {bus_if.mm_in_data_ready, bus_if.in_ready, busy});
    end
    step();
    checks++;
    if (bus_if.mm_in_data_ready !== 1'b0 || bus_if.mm_in_data !== 32'h04030201) begin
      errors++;
      $display("FAIL run_chunk0 got rdy=%b data=%h expected rdy=0 data=04030201",
               bus_if.mm_in_data_ready, bus_if.mm_in_data);
    end
    bus_if.mm_req_chunk_in = 1'b1;
    step();
    bus_if.mm_req_chunk_in = 1'b0;
    checks++;
    if (bus_if.mm_in_data !== 32'h08070605) begin
      errors++;
      $display("FAIL chunk1 got %h expected 08070605", bus_if.mm_in_data);
    end
    bus_if.mm_req_chunk_in = 1'b1;
    step();
    checks++;
    if (bus_if.mm_in_data !== 32'h0c0b0a09) begin
      errors++;
      $display("FAIL chunk2 got %h expected 0c0b0a09", bus_if.mm_in_data);
    end
    step();
    step();
    bus_if.mm_req_chunk_in = 1'b0;
    checks++;
    if (bus_if.mm_in_data !== 32'h04030201) begin
      errors++;
      $display("FAIL chunk_wrap got %h expected 04030201", bus_if.mm_in_data);
    end
    bus_if.mm_req_chunk_in = 1'b1;
    step();
    bus_if.mm_req_chunk_ptr_rst = 1'b1;
    step();
    bus_if.mm_req_chunk_in      = 1'b0;
    bus_if.mm_req_chunk_ptr_rst = 1'b0;
    checks++;
    if (bus_if.mm_in_data !== 32'h04030201) begin
      errors++;
      $display("FAIL rewind_priority got %h expected 04030201", bus_if.mm_in_data);
    end
  endtask

  task automatic test_capture_drain();
    logic [7:0] exp;
    logic [7:0] held;
    // continues in RUN from test_fill_and_chunks
    for (int i = 0; i < 8; i++) pulse_out(8'(-(i + 1)), (i == 7));
    checks++;
    if ({bus_if.out_valid, busy, err} !== 3'b110 || bus_if.out_elem !== 8'hff) begin
      errors++;
      $display("FAIL drain_entry got v/b/e=%b elem=%h expected 110 ff",
               {bus_if.out_valid, busy, err}, bus_if.out_elem);
    end
    for (int i = 0; i < 8; i++) begin
      exp  = 8'(-(i + 1));
      held = bus_if.out_elem;
      bus_if.out_ready = 1'b0;
      step();
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_elem !== held || bus_if.out_elem !== exp
          || bus_if.out_last !== (i == 7)) begin
        errors++;
        $display("FAIL drain_hold[%0d] got v=%b elem=%h last=%b expected 1 %h %b",
                 i, bus_if.out_valid, bus_if.out_elem, bus_if.out_last, exp, (i == 7));
      end
      bus_if.out_ready = 1'b1;
      step();
    end
    bus_if.out_ready = 1'b0;
    checks++;
    if ({bus_if.out_valid, busy, err, bus_if.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL after_drain got %b expected 0001", {bus_if.out_valid, busy, err, bus_if.in_ready});
    end
  endtask

  task automatic test_short_vector();
    logic [7:0] exp_s [8];
    exp_s = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd0, 8'd0};
    do_reset();
    fill_vec(40, 16);
    step();
    for (int i = 0; i < 6; i++) pulse_out(8'(10 + i), 1'b0);
    bus_if.mm_out_vector_valid = 1'b1;
    step();
    bus_if.mm_out_vector_valid = 1'b0;
    checks++;
    if ({bus_if.out_valid, err} !== 2'b11) begin
      errors++;
      $display("FAIL short_err got v/e=%b expected 11", {bus_if.out_valid, err});
    end
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_elem !== exp_s[i]) begin
        errors++;
        $display("FAIL short_drain[%0d] got v=%b elem=%h expected 1 %h", i, bus_if.out_valid, bus_if.out_elem, exp_s[i]);
      end
      step();
    end
    bus_if.out_ready = 1'b0;
    checks++;
    if ({bus_if.out_valid, busy, err} !== 3'b001) begin
      errors++;
      $display("FAIL short_end got %b expected 001", {bus_if.out_valid, busy, err});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    fill_vec(60, 16);
    step();
    for (int i = 0; i < 8; i++) pulse_out(8'(20 + i), 1'b0);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL overflow_pre got err=%b expected 0", err);
    end
    pulse_out(8'd99, 1'b0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err got err=%b busy=%b expected 1 1", err, busy);
    end
    bus_if.mm_out_vector_valid = 1'b1;
    step();
    bus_if.mm_out_vector_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus_if.out_valid !== 1'b1 || bus_if.out_elem !== 8'(20 + i)) begin
        errors++;
        $display("FAIL overflow_drain[%0d] got v=%b elem=%h expected 1 %h", i, bus_if.out_valid, bus_if.out_elem, 8'(20 + i));
      end
      step();
    end
    bus_if.out_ready = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    fill_vec(1, 16);
    step();
    // now in the first RUN cycle; advance to the 32nd
    for (int i = 0; i < 31; i++) step();
    checks++;
    if ({busy, err} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_pre got busy/err=%b expected 10", {busy, err});
    end
    step();
    checks++;
    if ({busy, err, bus_if.in_ready, bus_if.out_valid} !== 4'b0110) begin
      errors++;
      $display("FAIL timeout_abort got %b expected 0110", {busy, err, bus_if.in_ready, bus_if.out_valid});
    end
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    fill_vec(1, 16);
    step();
    pulse_out(8'd7, 1'b0);
    pulse_out(8'd8, 1'b1);
    checks++;
    if ({bus_if.out_valid, busy, err} !== 3'b111) begin
      errors++;
      $display("FAIL drain_before_reset got %b expected 111", {bus_if.out_valid, busy, err});
    end
    #2;
    rst_in = 1'b0;
    #1;
    checks++;
    if ({bus_if.out_valid, busy, err, bus_if.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset got %b expected 0001", {bus_if.out_valid, busy, err, bus_if.in_ready});
    end
    step();
    rst_in = 1'b1;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_in = 1'b0;
    test_reset();
    test_fill_and_chunks();
    test_capture_drain();
    test_short_vector();
    test_overflow();
    test_timeout();
    test_reset_in_drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vw_chunk_sequencer.md
# vw_chunk_sequencer

Controller that sequences one `vw_matmul` instance. It collects an input vector from an upstream element stream and serves it to the matmul in `WorkingRegs`-wide chunks on the matmul's chunk request/rewind strobes. It captures the output elements the matmul emits and replays the finished output vector to a downstream valid/ready stream. It sits between the audio feature pipeline and each fully-connected layer.

## Interface
Parameters:
- `InVecLength`, 16: input vector elements; must be a multiple of `WorkingRegs`.
- `OutVecLength`, 8: output vector elements.
- `WorkingRegs`, 4: chunk width in elements; must match the matmul.
- `NBits`, 8: element width, signed.
- `TimeoutCycles`, 4096: maximum cycles allowed in RUN before abort.

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream element valid.
- `in_ready` out 1: upstream element accepted when `in_valid & in_ready`.
- `in_elem` in NBits: upstream element, signed.
- `mm_in_data_ready` out 1: start pulse to the matmul.
- `mm_in_data` out WorkingRegs×NBits: current chunk; element k is `buf[chunk_ptr*WorkingRegs+k]`.
- `mm_req_chunk_in` in 1: advance the chunk pointer.
- `mm_req_chunk_ptr_rst` in 1: rewind the chunk pointer to 0.
- `mm_req_chunk_out` in 1: `mm_write_out_data` is valid this cycle.
- `mm_write_out_data` in NBits: output element from the matmul.
- `mm_out_vector_valid` in 1: the matmul has finished the vector.
- `out_valid` out 1: downstream element valid.
- `out_ready` in 1: downstream accept.
- `out_elem` out NBits: downstream element.
- `out_last` out 1: high with the final element of the vector.
- `busy` out 1: state is not FILL.
- `err` out 1: sticky error; cleared only by reset.

## Operation
States: FILL, START, RUN, DRAIN.

FILL
- `in_ready`=1.
- Each accepted element is written to `buf[fill_cnt]` and `fill_cnt` increments.
- On the accept that makes `fill_cnt`==`InVecLength`: go to START, clear `fill_cnt`, set `chunk_ptr`=0 and `out_wr_ptr`=0.

START
- Lasts one cycle. `mm_in_data_ready`=1 and `in_ready`=0.
- Next state is RUN.
- `mm_in_data_ready` is 0 in every other state.

RUN
- Chunk pointer update:
  - `mm_req_chunk_ptr_rst` sets `chunk_ptr` to 0. It has priority over `mm_req_chunk_in`.
  - Otherwise, `mm_req_chunk_in` increments `chunk_ptr`, wrapping `InVecLength/WorkingRegs-1` to 0.
- Output capture:
  - `mm_req_chunk_out` writes `mm_write_out_data` to `obuf[out_wr_ptr]` and increments `out_wr_ptr`.
  - If `out_wr_ptr`==`OutVecLength` at that strobe, the write is dropped and `err` is set.
- Completion:
  - `mm_out_vector_valid` (the final write in the same cycle is still captured) moves to DRAIN with `out_rd_ptr`=0.
  - If the post-capture count is not `OutVecLength`, `err` is set and DRAIN still runs over `OutVecLength` entries. Unwritten entries read 0.
- Watchdog: `run_cnt` counts RUN cycles. When it reaches `TimeoutCycles` with no completion, set `err`, return to FILL and discard `buf`.

DRAIN
- `out_valid`=1 and `out_elem`=`obuf[out_rd_ptr]`.
- `out_last`=(`out_rd_ptr`==`OutVecLength-1`).
- Each `out_valid & out_ready` increments `out_rd_ptr`. The handshake on the last element returns to FILL.
- `out_elem` and `out_last` are held stable while `out_valid & ~out_ready`.

General rules
- Matmul strobes outside RUN are ignored; none of them sets `err`.
- `obuf` is cleared to 0 on entry to RUN.
- No arithmetic on element data; elements pass through unmodified at `NBits` signed.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert):
  - State is FILL; all pointers, counters and `err` are 0.
  - `in_ready`=1. `mm_in_data_ready`, `out_valid`, `out_last`, `busy` and `mm_in_data` are 0.
  - Reset mid-vector discards all buffered data.
- `mm_in_data` is combinational from the registered `chunk_ptr`. A request strobe at cycle t presents the new chunk at t+1, which matches the matmul's single-cycle chunk fetch.
- Latency from the last input accept to `mm_in_data_ready`: 1 cycle (START is the cycle after the accept).
- Latency from `mm_out_vector_valid` to first `out_valid`: 1 cycle.
- `busy` is high from START through the final DRAIN handshake.
- Throughput: one vector per FILL+START+RUN+DRAIN. FILL never overlaps RUN.

## Test plan
- Defaults, elements 1..16 streamed back-to-back:
  - `mm_in_data_ready` pulses once, exactly 1 cycle after the 16th accept.
  - `mm_in_data` = {1,2,3,4}; after `mm_req_chunk_in` it is {5,6,7,8} the next cycle.
- Chunk wrap and rewind:
  - 4 `mm_req_chunk_in` strobes give chunk 0 again.
  - `mm_req_chunk_in` and `mm_req_chunk_ptr_rst` together give chunk 0.
- Capture and drain:
  - 8 `mm_req_chunk_out` strobes with data -1..-8, the last one coincident with `mm_out_vector_valid`.
  - Output is -1..-8 with `out_last` only on -8.
  - Toggling `out_ready` holds data stable.
- Short vector: `mm_out_vector_valid` after only 6 strobes sets `err`; drain emits 6 values then 0,0.
- Overflow: a 9th `mm_req_chunk_out` before completion sets `err`; `obuf` contents are unchanged.
- Timeout and reset:
  - With `TimeoutCycles`=32, 32 silent RUN cycles give FILL with `err`=1.
  - Asserting `rst_in` during DRAIN immediately clears `out_valid`, `busy` and `err`.
